// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: icodes, condition selectors, CC bit layout.
// Also carries the E->M boundary bundle used by the execute stage.
package y86_pkg;

  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;

  localparam logic [3:0] C_YES = 4'd0;
  localparam logic [3:0] C_LE  = 4'd1;
  localparam logic [3:0] C_L   = 4'd2;
  localparam logic [3:0] C_E   = 4'd3;
  localparam logic [3:0] C_NE  = 4'd4;
  localparam logic [3:0] C_GE  = 4'd5;
  localparam logic [3:0] C_G   = 4'd6;

  localparam int CC_OF = 0;
  localparam int CC_ZF = 1;
  localparam int CC_SF = 2;

  localparam logic [2:0] CC_RST = 3'b010;

  typedef struct packed {
    logic valid;
    logic cnd;
    logic mispredict;
  } em_t;

endpackage

// File: rtl/cc_cond_unit_cond_eval.sv
// Combinational jXX/cmovXX condition evaluation from CC and ifun.
// Selectors outside the defined set evaluate to not-taken.
module cond_eval
  import y86_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] ifun,
  output logic       cnd
);

  logic sf;
  logic of;
  logic zf;
  logic lt;

  assign sf = cc[CC_SF];
  assign of = cc[CC_OF];
  assign zf = cc[CC_ZF];
  assign lt = sf ^ of;

  always_comb begin
    cnd = 1'b0;
    case (ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = lt | zf;
      C_L:     cnd = lt;
      C_E:     cnd = zf;
      C_NE:    cnd = ~zf;
      C_GE:    cnd = ~lt;
      C_G:     cnd = ~lt & ~zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/cc_cond_unit.sv
// Execute-stage CC register and condition unit for the Y86-64 pipeline.
// Latches ALU flags on OPq and registers Cnd/mispredict into E->M.
module cc_cond_unit #(
  parameter int              CC_W   = 3,
  parameter logic [CC_W-1:0] CC_RST = y86_pkg::CC_RST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CC_W-1:0] cf_in,
  input  logic            e_valid,
  input  logic [3:0]      e_icode,
  input  logic [3:0]      e_ifun,
  input  logic            m_exc,
  input  logic            w_exc,
  input  logic            stall,
  input  logic            bubble,
  output logic [CC_W-1:0] cc,
  output logic            e_cnd,
  output logic            m_cnd,
  output logic            m_valid,
  output logic            m_mispredict
);

  import y86_pkg::*;

  logic [CC_W-1:0] cc_d;
  logic [CC_W-1:0] cc_q;
  em_t             em_d;
  em_t             em_q;
  logic            cc_we;

  cond_eval u_cond_eval (
    .cc   (cc_q),
    .ifun (e_ifun),
    .cnd  (e_cnd)
  );

  // Older faulting instructions must not let a younger OPq commit flags.
  assign cc_we = e_valid & (e_icode == IOPQ) & ~m_exc & ~w_exc & ~stall;

  always_comb begin
    cc_d = cc_q;
    if (cc_we) begin
      cc_d = cf_in;
    end
  end

  always_comb begin
    em_d = em_q;
    if (bubble) begin
      em_d = '0;
    end else if (!stall) begin
      em_d.valid      = e_valid;
      em_d.cnd        = e_cnd & e_valid;
      em_d.mispredict = e_valid & (e_icode == IJXX) & ~e_cnd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_q <= CC_RST;
      em_q <= '0;
    end else begin
      cc_q <= cc_d;
      em_q <= em_d;
    end
  end

  assign cc           = cc_q;
  assign m_cnd        = em_q.cnd;
  assign m_valid      = em_q.valid;
  assign m_mispredict = em_q.mispredict;

endmodule
